// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned PTR_W_DEF     = $clog2(NREQ_DEF);
  localparam int unsigned CNT_W_DEF     = $clog2(MAX_BURST_DEF + 1);

  function automatic int unsigned ptr_w(input int unsigned nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req scanning upward from start, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(start) + i) % N;
      if (!found && req[W'(j)]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ valid/ready streams,
// with an optional bounded burst lock per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = NREQ_DEF,
  parameter  int unsigned DW        = DW_DEF,
  parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
  localparam int unsigned PW        = ptr_w(NREQ),
  localparam int unsigned CW        = cnt_w(MAX_BURST)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               buf_full,
  output logic               wr_en,
  output logic [DW-1:0]      buf_in,
  output logic [PW-1:0]      grant_id,
  output logic               busy
);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [DW-1:0] lane [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DW +: DW];
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (32'(p) == NREQ - 1) ? '0 : p + PW'(1);
  endfunction

  rr_pick #(
    .N (NREQ),
    .W (PW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state and same-cycle write-port drive
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    wr_en      = 1'b0;
    buf_in     = '0;
    req_ready  = '0;
    grant_id   = '0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id = pick_idx;
          if (!buf_full) begin
            wr_en               = 1'b1;
            buf_in              = lane[pick_idx];
            req_ready[pick_idx] = 1'b1;
            if (MAX_BURST > 1) begin
              owner_d    = pick_idx;
              beat_cnt_d = CW'(1);
              state_d    = BURST;
            end else begin
              rr_ptr_d = next_ptr(pick_idx);
            end
          end
        end
      end
      BURST: begin
        busy     = 1'b1;
        grant_id = owner_q;
        if (!req_valid[owner_q]) begin
          // Owner went quiet: give up the lock, nobody writes this cycle.
          rr_ptr_d = next_ptr(owner_q);
          state_d  = IDLE;
        end else if (!buf_full) begin
          wr_en              = 1'b1;
          buf_in             = lane[owner_q];
          req_ready[owner_q] = 1'b1;
          beat_cnt_d         = beat_cnt_q + CW'(1);
          if (beat_cnt_d == CW'(MAX_BURST)) begin
            rr_ptr_d = next_ptr(owner_q);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      wr_en     = 1'b0;
      buf_in    = '0;
      req_ready = '0;
      grant_id  = '0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed checks of fifo_wr_arbiter (MAX_BURST=1 and 4) against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned GW   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic               buf_full;
  logic [NREQ-1:0]    rdy1, rdy4;
  logic               wr1, wr4, busy1, busy4;
  logic [DW-1:0]      bin1, bin4;
  logic [GW-1:0]      gid1, gid4;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .buf_full(buf_full), .wr_en(wr1), .buf_in(bin1),
    .grant_id(gid1), .busy(busy1)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy4), .buf_full(buf_full), .wr_en(wr4), .buf_in(bin4),
    .grant_id(gid4), .busy(busy4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: index 0 is the MAX_BURST=1 instance, index 1 the MAX_BURST=4 instance.
  int mbv    [2] = '{1, 4};
  int ptr    [2];
  int own    [2];
  int left   [2];
  bit locked [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ptr[m] = 0; own[m] = 0; left[m] = 0; locked[m] = 1'b0;
    end
  endtask

  function automatic logic [31:0] beat_of(input int i);
    logic [31:0] t;
    t = req_data >> (i * DW);
    return {24'b0, t[7:0]};
  endfunction

  task automatic model_eval(input int m, output logic [31:0] e_wr, output logic [31:0] e_rdy,
                            output logic [31:0] e_dat, output logic [31:0] e_gid,
                            output logic [31:0] e_busy);
    int w;
    e_wr = 0; e_rdy = 0; e_dat = 0; e_gid = 0; e_busy = 0;
    if (!locked[m]) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[GW'((ptr[m] + k) % NREQ)]) w = (ptr[m] + k) % NREQ;
      if (w >= 0) begin
        e_gid = w;
        if (!buf_full) begin
          e_wr = 1; e_rdy = 1 << w; e_dat = beat_of(w);
          if (mbv[m] > 1) begin
            locked[m] = 1'b1; own[m] = w; left[m] = mbv[m] - 1;
          end else begin
            ptr[m] = (w + 1) % NREQ;
          end
        end
      end
    end else begin
      e_busy = 1; e_gid = own[m];
      if (!req_valid[GW'(own[m])]) begin
        locked[m] = 1'b0; ptr[m] = (own[m] + 1) % NREQ;
      end else if (!buf_full) begin
        e_wr = 1; e_rdy = 1 << own[m]; e_dat = beat_of(own[m]);
        left[m]--;
        if (left[m] == 0) begin
          locked[m] = 1'b0; ptr[m] = (own[m] + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] ew, er, ed, eg, eb;
    model_eval(0, ew, er, ed, eg, eb);
    check("m1.wr_en", 32'(wr1), ew);   check("m1.req_ready", 32'(rdy1), er);
    check("m1.buf_in", 32'(bin1), ed); check("m1.grant_id", 32'(gid1), eg);
    check("m1.busy", 32'(busy1), eb);
    model_eval(1, ew, er, ed, eg, eb);
    check("m4.wr_en", 32'(wr4), ew);   check("m4.req_ready", 32'(rdy4), er);
    check("m4.buf_in", 32'(bin4), ed); check("m4.grant_id", 32'(gid4), eg);
    check("m4.busy", 32'(busy4), eb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic [NREQ-1:0] v, input logic [31:0] d, input logic f);
    req_valid = v; req_data = d; buf_full = f;
    #3;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wr1"}, 32'(wr1), 0);     check({tag, ".wr4"}, 32'(wr4), 0);
    check({tag, ".rdy1"}, 32'(rdy1), 0);   check({tag, ".rdy4"}, 32'(rdy4), 0);
    check({tag, ".bin1"}, 32'(bin1), 0);   check({tag, ".bin4"}, 32'(bin4), 0);
    check({tag, ".gid1"}, 32'(gid1), 0);   check({tag, ".gid4"}, 32'(gid4), 0);
    check({tag, ".busy1"}, 32'(busy1), 0); check({tag, ".busy4"}, 32'(busy4), 0);
  endtask

  // Asynchronous reset with every requester valid; ends just after a rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; req_valid = '1; req_data = 32'hA3A2A1A0; buf_full = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] v;
    int pv, pf;
    rst_n = 1'b1; req_valid = '0; req_data = '0; buf_full = 1'b0;
    model_reset();
    #1;
    do_reset("reset");

    // Round-robin after reset; the lock-4 instance drains req0 then req1
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'hF, 32'hA3A2A1A0, 1'b0);
      check("rr.m1.data", 32'(bin1), 32'hA0 + 32'(k % 4));
      check("rr.m4.data", 32'(bin4), 32'hA0 + 32'(k / 4));
      check("rr.m4.busy", 32'(busy4), 32'(k % 4 != 0));
      tick();
    end

    // Burst lock with req1 and req2 contending
    do_reset("rst_burst");
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'b0110, 32'hB3B2B1B0, 1'b0);
      check("burst.m4.data", 32'(bin4), (k < 4) ? 32'hB1 : 32'hB2);
      check("burst.m1.data", 32'(bin1), (k % 2 == 0) ? 32'hB1 : 32'hB2);
      tick();
    end

    // Early release: req1 drops after two beats
    do_reset("rst_early");
    run_cycle(4'b0110, 32'hB3B2B1B0, 1'b0); tick();
    run_cycle(4'b0110, 32'hB3B2B1B0, 1'b0); tick();
    run_cycle(4'b0100, 32'hB3B2B1B0, 1'b0);
    check("early.idle_wr", 32'(wr4), 0);
    tick();
    run_cycle(4'b0100, 32'hB3B2B1B0, 1'b0);
    check("early.next_wr", 32'(wr4), 1);
    check("early.next_id", 32'(gid4), 2);
    check("early.next_dat", 32'(bin4), 32'hB2);
    tick();

    // Full mid-burst for three cycles
    do_reset("rst_full");
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'b0010, 32'hC3C2C1C0, (k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) begin
        check("full.wr", 32'(wr4), 0);
        check("full.rdy", 32'(rdy4), 0);
        check("full.busy", 32'(busy4), 1);
      end
      if (k == 7) begin
        check("full.relock_busy", 32'(busy4), 0);
        check("full.relock_wr", 32'(wr4), 1);
      end
      tick();
    end

    // Full while idle never locks
    do_reset("rst_fidle");
    for (int k = 0; k < 2; k++) begin
      run_cycle(4'hF, 32'hA3A2A1A0, 1'b1);
      check("fidle.busy", 32'(busy4), 0);
      check("fidle.wr", 32'(wr4), 0);
      tick();
    end
    run_cycle(4'hF, 32'hA3A2A1A0, 1'b0);
    check("fidle.first", 32'(bin4), 32'hA0);
    tick();

    // Reset mid-burst
    do_reset("rst_mid0");
    run_cycle(4'hF, 32'hA3A2A1A0, 1'b0); tick();
    run_cycle(4'hF, 32'hA3A2A1A0, 1'b0); tick();
    do_reset("rst_mid");
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'hF, 32'hA3A2A1A0, 1'b0);
      check("mid.m4.data", 32'(bin4), (k < 4) ? 32'hA0 : 32'hA1);
      tick();
    end

    // Randomized traffic at several valid densities and full rates
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 95 : 50;
      pf = (ph == 0) ? 0  : (ph == 1) ? 20 : (ph == 2) ? 50 : 10;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(199) == 0) do_reset("rnd_rst");
        for (int b = 0; b < NREQ; b++) v[b] = ($urandom_range(99) < pv);
        run_cycle(v, $urandom, ($urandom_range(99) < pf));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single-clock FIFO's write side between `NREQ` requesters. Each requester presents a valid/ready byte stream. The arbiter picks one winner per cycle, optionally locks it for a bounded burst, and drives the FIFO `wr_en`/`buf_in` pair. It honours `buf_full` so that no beat is ever dropped or duplicated.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: data width; matches the FIFO `buf_in` width.
- `MAX_BURST`, 4: maximum beats per grant lock, 1..16.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i has a beat available.
- `req_data`  in  NREQ*DW: beat of requester i occupies bits `[i*DW +: DW]`.
- `req_ready`  out  NREQ: one-hot or zero; a beat is consumed when `req_valid[i] & req_ready[i]`.
- `buf_full`  in  1: FIFO full flag.
- `wr_en`  out  1: FIFO write strobe.
- `buf_in`  out  DW: FIFO write data.
- `grant_id`  out  clog2(NREQ): current winner or owner; 0 when idle with no request.
- `busy`  out  1: high while in BURST (grant locked).

## Operation
- State machine: IDLE, BURST. Registers: `state`, `rr_ptr` (clog2(NREQ)), `owner` (clog2(NREQ)), `beat_cnt` (clog2(MAX_BURST+1)).
- Reset: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0. While `rst_n`=0, `wr_en`=0, `req_ready`=0, `buf_in`=0, `grant_id`=0 and `busy`=0.
- **IDLE**
  - The winner is the first `req_valid` bit found scanning upward from `rr_ptr`, wrapping modulo NREQ.
  - If there is a winner and `!buf_full`: transfer one beat (`wr_en`=1, `buf_in`=winner data, `req_ready[winner]`=1).
  - If `MAX_BURST`>1 after that transfer: owner=winner, beat_cnt=1, go to BURST.
  - If `MAX_BURST`=1 after that transfer: rr_ptr=winner+1 (mod NREQ) and stay in IDLE.
  - If there is a winner but `buf_full`=1: no transfer and no lock; re-arbitrate next cycle with rr_ptr unchanged.
- **BURST**: only the owner is eligible.
  - If owner valid and `!buf_full`: transfer and increment beat_cnt. If the new beat_cnt equals MAX_BURST, set rr_ptr=owner+1 and go to IDLE.
  - If owner valid and `buf_full`=1: no transfer; hold the state and freeze beat_cnt.
  - If owner valid is low: release the lock; set rr_ptr=owner+1 and go to IDLE. No transfer from any requester in this cycle.
- Outputs are combinational from state, `req_valid`, `req_data` and `buf_full`. When `wr_en`=0, `buf_in`=0.
- `wr_en` equals the OR of `req_valid & req_ready`, so exactly one beat is consumed per write.

## Timing
- Zero-cycle latency: from valid to `wr_en` in the same cycle. The FIFO captures the data at the next rising edge.
- `buf_full` is a decode of registered FIFO state, so there is no combinational loop through the arbiter.
- Throughput is one beat per cycle whenever the FIFO is not full. A burst release caused by valid going low costs one idle cycle.
- Fairness: any continuously valid requester is served within (NREQ-1)*MAX_BURST transferred beats.
- Reset asserted mid-burst forces IDLE immediately and asynchronously. No partial beat is written.
- Full during IDLE never locks a requester.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - localparams for pointer width clog2(NREQ) and counter width clog2(MAX_BURST+1).
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are `req` and `start`; outputs are `found` and `idx`. It is used once in IDLE.
- The top level holds the FSM, the registers and the output muxing.

## Test plan
- Reset state: hold `rst_n`=0 with all `req_valid`=1 -> `wr_en`=0, `req_ready`=0, `busy`=0. After release with `MAX_BURST`=1, the first beat comes from req 0.
- Round-robin: `MAX_BURST`=1, all 4 valid for 8 cycles, data i=8'hA0+i -> FIFO receives A0,A1,A2,A3,A0,A1,A2,A3.
- Burst lock: `MAX_BURST`=4, req1 and req2 both valid -> beats 1,1,1,1,2,2,2,2. `busy` is high from the cycle after the first beat through the 4th beat.
- Early release: req1 drops valid after 2 beats of its burst -> one idle cycle, then req2 is granted and rr_ptr=2.
- Full backpressure: assert `buf_full` mid-burst for 3 cycles -> `wr_en`=0 and `req_ready`=0 during those cycles, beat_cnt frozen, burst resumes without loss or duplication. Full in IDLE leaves `busy`=0.
- Reset mid-burst: deassert `rst_n` after 2 beats -> outputs go to 0 asynchronously. After release, arbitration restarts at req 0 with a fresh burst count.
